ex_stage: RTL

Execute stage of the five-stage pipeline, plus the EX/MEM pipeline register. It selects the ALU operands using the `forwardA`/`forwardB` codes from the forwarding unit, executes the ALU operation and registers the result and MEM/WB control into EX/MEM. Its registered outputs `mem_reg_write` and `mem_rd` drive the forwarding unit's EX-hazard inputs (`EXregwrite`, `exRd`), closing the forwarding loop.

---
 rtl/ex_stage.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage with EX/MEM pipeline register: operand forwarding, ALU, zero
// and overflow detection, plus the registered MEM/WB control fields.
module ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic [4:0]        shamt,
  input  logic [3:0]        alu_op,
  input  logic              alu_src,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic [4:0]        dest_rd,
  input  logic [1:0]        forwardA,
  input  logic [1:0]        forwardB,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [4:0]        mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic              mem_zero,
  output logic              mem_ovf
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_LUI  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_ovf;

  // Code 01 reads this stage's own registered result, so a held (stalled)
  // result keeps being forwarded until the register reloads.
  always_comb begin
    fwd_a = rs_data;
    case (forwardA)
      2'b01:   fwd_a = mem_alu_result;
      2'b10:   fwd_a = wb_data;
      default: fwd_a = rs_data;
    endcase
  end

  always_comb begin
    fwd_b = rt_data;
    case (forwardB)
      2'b01:   fwd_b = mem_alu_result;
      2'b10:   fwd_b = wb_data;
      default: fwd_b = rt_data;
    endcase
  end

  assign op_b = alu_src ? imm : fwd_b;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_AND:  alu_result = fwd_a & op_b;
      OP_OR:   alu_result = fwd_a | op_b;
      OP_XOR:  alu_result = fwd_a ^ op_b;
      OP_NOR:  alu_result = ~(fwd_a | op_b);
      OP_ADD:  alu_result = fwd_a + op_b;
      OP_SUB:  alu_result = fwd_a - op_b;
      OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      OP_SLTU: alu_result = {{(DATA_W-1){1'b0}}, (fwd_a < op_b)};
      OP_SLL:  alu_result = op_b << shamt;
      OP_SRL:  alu_result = op_b >> shamt;
      OP_SRA:  alu_result = $signed(op_b) >>> shamt;
      OP_LUI:  alu_result = op_b << 16;
      default: alu_result = '0;
    endcase
  end

  assign alu_zero = (alu_result == '0);

  // Sign-bit overflow test: ADD needs like-signed operands, SUB unlike-signed,
  // and in both cases the result sign must have moved away from A.
  always_comb begin
    alu_ovf = 1'b0;
    case (alu_op)
      OP_ADD:  alu_ovf = (fwd_a[DATA_W-1] == op_b[DATA_W-1]) &&
                         (alu_result[DATA_W-1] != fwd_a[DATA_W-1]);
      OP_SUB:  alu_ovf = (fwd_a[DATA_W-1] != op_b[DATA_W-1]) &&
                         (alu_result[DATA_W-1] != fwd_a[DATA_W-1]);
      default: alu_ovf = 1'b0;
    endcase
  end

  // A bubble clears both mem_reg_write and mem_rd so the forwarding unit
  // can never match on it.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_zero       <= 1'b0;
      mem_ovf        <= 1'b0;
    end else if (!stall) begin
      mem_alu_result <= alu_result;
      mem_store_data <= fwd_b;
      mem_rd         <= dest_rd;
      mem_reg_write  <= reg_write & ~alu_ovf;
      mem_mem_read   <= mem_read  & ~alu_ovf;
      mem_mem_write  <= mem_write & ~alu_ovf;
      mem_mem_to_reg <= mem_to_reg;
      mem_zero       <= alu_zero;
      mem_ovf        <= alu_ovf;
    end
  end

endmodule
